// File: rtl/i2d_mau_wb.sv
// i2d_mau_wb: data-side memory access unit running one Wishbone classic single-beat cycle per request.
// Optional bus watchdog is enabled by defining I2D_MAU_TIMEOUT_EN.
module i2d_mau_wb #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int RETRY_MAX   = 3,
  parameter int RETRY_GAP   = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mau_dis,
  input  logic            mau_flush,
  input  logic [1:0]      mau_op,
  input  logic [1:0]      mau_size,
  input  logic            mau_sign,
  input  logic [AW-1:0]   mau_addr,
  input  logic [DW-1:0]   datain,
  output logic [DW-1:0]   data_out,
  output logic            busy,
  output logic            done,
  output logic            mau_err,
  output logic [AW-1:0]   adr_o,
  input  logic [DW-1:0]   dat_i,
  output logic [DW-1:0]   dat_o,
  input  logic            ack_i,
  input  logic            err_i,
  input  logic            try_i,
  output logic            cyc_o,
  output logic            stb_o,
  output logic [DW/8-1:0] sel_o,
  output logic            we_o
);

  localparam int SW = DW / 8;
  localparam int LB = $clog2(SW);
  localparam int RW = $clog2(RETRY_MAX + 2);
  localparam int GW = $clog2(RETRY_GAP + 1);

  if (!(DW == 32 || DW == 64) || RETRY_GAP < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("i2d_mau_wb: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_WAIT, S_DONE} state_t;

  state_t          state, state_nxt;
  logic            req_ok, misalign;
  logic            go_bus, go_err, retry_inc, load_cap, bus_timeout;
  logic [RW-1:0]   retry_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [LB-1:0]   lo_q;
  logic [1:0]      size_q;
  logic            sign_q;
  logic [SW-1:0]   size_mask, sel_nxt;
  logic [DW-1:0]   wdata, shifted, load_val;

  assign req_ok = (mau_op == 2'b01 || mau_op == 2'b10) && !mau_dis && !mau_flush;

  always_comb begin
    misalign = 1'b0;
    case (mau_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = mau_addr[0];
      2'b10:   misalign = |mau_addr[1:0];
      default: misalign = (DW == 32) ? 1'b1 : |mau_addr[LB-1:0];
    endcase
  end

  always_comb begin
    size_mask = '1;
    wdata     = datain;
    case (mau_size)
      2'b00: begin
        size_mask = SW'(1);
        wdata     = {SW{datain[7:0]}};
      end
      2'b01: begin
        size_mask = SW'(3);
        wdata     = {(DW/16){datain[15:0]}};
      end
      2'b10: begin
        size_mask = SW'(15);
        wdata     = {(DW/32){datain[31:0]}};
      end
      default: begin
        size_mask = '1;
        wdata     = datain;
      end
    endcase
  end

  assign sel_nxt = size_mask << mau_addr[LB-1:0];

  // Bring the addressed lanes down to bit 0, then truncate and extend to the access size.
  assign shifted = dat_i >> {lo_q, 3'b000};

  always_comb begin
    load_val = shifted;
    case (size_q)
      2'b00:   load_val = sign_q ? DW'($signed(shifted[7:0]))  : DW'(shifted[7:0]);
      2'b01:   load_val = sign_q ? DW'($signed(shifted[15:0])) : DW'(shifted[15:0]);
      2'b10:   load_val = sign_q ? DW'($signed(shifted[31:0])) : DW'(shifted[31:0]);
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Flush is tested before any bus termination so it always wins.
  always_comb begin
    state_nxt = state;
    go_bus    = 1'b0;
    go_err    = 1'b0;
    retry_inc = 1'b0;
    load_cap  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_ok) begin
          if (misalign) begin
            state_nxt = S_DONE;
            go_err    = 1'b1;
          end else begin
            state_nxt = S_BUS;
            go_bus    = 1'b1;
          end
        end
      end
      S_BUS: begin
        if (mau_flush) begin
          state_nxt = S_IDLE;
        end else if (err_i) begin
          state_nxt = S_DONE;
          go_err    = 1'b1;
        end else if (try_i) begin
          if (retry_cnt < RW'(RETRY_MAX)) begin
            state_nxt = S_WAIT;
            retry_inc = 1'b1;
          end else begin
            state_nxt = S_DONE;
            go_err    = 1'b1;
          end
        end else if (ack_i) begin
          state_nxt = S_DONE;
          load_cap  = !we_o;
        end else if (bus_timeout) begin
          state_nxt = S_DONE;
          go_err    = 1'b1;
        end
      end
      S_WAIT: begin
        if (mau_flush)                          state_nxt = S_IDLE;
        else if (gap_cnt == GW'(RETRY_GAP - 1)) state_nxt = S_BUS;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retry_cnt <= '0;
      gap_cnt   <= '0;
      mau_err   <= 1'b0;
      data_out  <= '0;
    end else begin
      if (retry_inc)                retry_cnt <= retry_cnt + RW'(1);
      else if (state_nxt == S_IDLE) retry_cnt <= '0;
      gap_cnt <= (state == S_WAIT && state_nxt == S_WAIT) ? gap_cnt + GW'(1) : '0;
      mau_err <= go_err;
      if (load_cap) data_out <= load_val;
    end
  end

  // Request fields are captured once at accept and replayed unchanged on every reissue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adr_o  <= '0;
      sel_o  <= '0;
      we_o   <= 1'b0;
      dat_o  <= '0;
      lo_q   <= '0;
      size_q <= 2'b00;
      sign_q <= 1'b0;
    end else if (go_bus) begin
      adr_o  <= {mau_addr[AW-1:LB], {LB{1'b0}}};
      sel_o  <= sel_nxt;
      we_o   <= (mau_op == 2'b10);
      dat_o  <= wdata;
      lo_q   <= mau_addr[LB-1:0];
      size_q <= mau_size;
      sign_q <= mau_sign;
    end
  end

`ifdef I2D_MAU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_cnt <= '0;
    else      tmo_cnt <= (state == S_BUS && state_nxt == S_BUS) ? tmo_cnt + TW'(1) : '0;
  end

  assign bus_timeout = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign bus_timeout = 1'b0;
`endif

  assign cyc_o = (state == S_BUS);
  assign stb_o = cyc_o;
  assign busy  = (state == S_BUS) || (state == S_WAIT);
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_i2d_mau_wb.sv
// tb_i2d_mau_wb: directed and randomized accesses for i2d_mau_wb (DW=32) checked against a
// byte-level reference model; covers the watchdog when I2D_MAU_TIMEOUT_EN is defined.
module tb_i2d_mau_wb;

  localparam int AW          = 32;
  localparam int DW          = 32;
  localparam int RETRY_MAX   = 3;
  localparam int RETRY_GAP   = 2;
  localparam int TIMEOUT_CYC = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mau_dis, mau_flush, mau_sign;
  logic [1:0]    mau_op, mau_size;
  logic [AW-1:0] mau_addr;
  logic [DW-1:0] datain, data_out, dat_i, dat_o;
  logic          busy, done, mau_err;
  logic [AW-1:0] adr_o;
  logic          ack_i, err_i, try_i, cyc_o, stb_o, we_o;
  logic [3:0]    sel_o;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [31:0]   exp_data = 32'h0;

  i2d_mau_wb #(
    .AW(AW), .DW(DW), .RETRY_MAX(RETRY_MAX), .RETRY_GAP(RETRY_GAP), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .mau_dis(mau_dis), .mau_flush(mau_flush), .mau_op(mau_op),
    .mau_size(mau_size), .mau_sign(mau_sign), .mau_addr(mau_addr), .datain(datain),
    .data_out(data_out), .busy(busy), .done(done), .mau_err(mau_err), .adr_o(adr_o),
    .dat_i(dat_i), .dat_o(dat_o), .ack_i(ack_i), .err_i(err_i), .try_i(try_i),
    .cyc_o(cyc_o), .stb_o(stb_o), .sel_o(sel_o), .we_o(we_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: accesses described in bytes, independent of lane hardware.
  function automatic bit m_misaligned(input logic [1:0] size, input logic [31:0] addr);
    int nb;
    nb = 1 << size;
    return (size == 2'b11) || ((addr % nb) != 0);
  endfunction

  function automatic logic [3:0] m_sel(input logic [1:0] size, input logic [31:0] addr);
    int nb;
    int mask;
    nb   = 1 << size;
    mask = ((1 << nb) - 1) << (addr % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_wdat(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    int nb;
    nb = 1 << size;
    r  = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input bit sgn,
                                         input logic [31:0] addr, input logic [31:0] bus);
    logic [63:0] v;
    int nb;
    nb = 1 << size;
    v  = {32'h0, bus} >> (8 * (addr % 4));
    v  = v & ((64'd1 << (8 * nb)) - 64'd1);
    if (sgn && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  // One full request: accept, n_try retry terminations, then ack (or err), with gap and result checks.
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] size, input bit sgn,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rd, input int n_try, input bit bus_err);
    bit exp_err;
    bit fin;
    int attempt;
    mau_op = op; mau_size = size; mau_sign = sgn; mau_addr = addr; datain = wd;
    step();
    if (!(op == 2'b01 || op == 2'b10)) begin
      mau_op = 2'b00;
      checkOutput("noop_busy", 64'(busy), 64'(0));
      checkOutput("noop_cyc", 64'(cyc_o), 64'(0));
      step();
      checkOutput("noop_done", 64'(done), 64'(0));
      return;
    end
    if (m_misaligned(size, addr)) begin
      mau_op = 2'b00;
      checkOutput("mis_cyc", 64'(cyc_o), 64'(0));
      checkOutput("mis_done", 64'(done), 64'(1));
      checkOutput("mis_err", 64'(mau_err), 64'(1));
      checkOutput("mis_busy", 64'(busy), 64'(0));
      step();
      checkOutput("mis_done_clr", 64'(done), 64'(0));
      return;
    end
    // Junk on the request inputs while busy must be ignored.
    mau_op = 2'($urandom); mau_addr = $urandom; datain = $urandom;
    mau_size = 2'($urandom); mau_sign = 1'($urandom);
    attempt = 0;
    fin = 1'b0;
    while (!fin) begin
      checkOutput("bus_cyc", 64'(cyc_o), 64'(1));
      checkOutput("bus_stb", 64'(stb_o), 64'(1));
      checkOutput("bus_busy", 64'(busy), 64'(1));
      checkOutput("bus_adr", 64'(adr_o), 64'(addr - (addr % 4)));
      checkOutput("bus_sel", 64'(sel_o), 64'(m_sel(size, addr)));
      checkOutput("bus_we", 64'(we_o), 64'(op == 2'b10));
      if (op == 2'b10) checkOutput("bus_dat", 64'(dat_o), 64'(m_wdat(size, wd)));
      if (attempt < n_try) try_i = 1'b1;
      else if (bus_err)    err_i = 1'b1;
      else begin
        ack_i = 1'b1;
        dat_i = rd;
      end
      step();
      ack_i = 1'b0; err_i = 1'b0; try_i = 1'b0; dat_i = $urandom;
      if (attempt < n_try && attempt < RETRY_MAX) begin
        for (int g = 0; g < RETRY_GAP; g++) begin
          checkOutput("gap_cyc", 64'(cyc_o), 64'(0));
          checkOutput("gap_busy", 64'(busy), 64'(1));
          checkOutput("gap_done", 64'(done), 64'(0));
          step();
        end
        attempt++;
      end else begin
        fin = 1'b1;
      end
    end
    exp_err = bus_err || (n_try > RETRY_MAX);
    if (op == 2'b01 && !exp_err) exp_data = m_load(size, sgn, addr, rd);
    mau_op = 2'b00;
    checkOutput("end_done", 64'(done), 64'(1));
    checkOutput("end_err", 64'(mau_err), 64'(exp_err));
    checkOutput("end_busy", 64'(busy), 64'(0));
    checkOutput("end_cyc", 64'(cyc_o), 64'(0));
    checkOutput("end_data", 64'(data_out), 64'(exp_data));
    step();
    checkOutput("end_done_clr", 64'(done), 64'(0));
    checkOutput("end_err_clr", 64'(mau_err), 64'(0));
  endtask

  initial begin
    logic [1:0]  r_op, r_size;
    logic [31:0] r_addr;
    mau_dis = 1'b0; mau_flush = 1'b0; mau_op = 2'b00; mau_size = 2'b00; mau_sign = 1'b0;
    mau_addr = '0; datain = '0; dat_i = '0; ack_i = 1'b0; err_i = 1'b0; try_i = 1'b0;

    #12;
    checkOutput("rst_cyc", 64'(cyc_o), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_err", 64'(mau_err), 64'(0));
    checkOutput("rst_sel", 64'(sel_o), 64'(0));
    checkOutput("rst_data", 64'(data_out), 64'(0));
    checkOutput("rst_adr", 64'(adr_o), 64'(0));
    checkOutput("rst_we", 64'(we_o), 64'(0));
    rst = 1'b1;
    step();

    $display("[TB] directed accesses");
    applyStimulus(2'b01, 2'b10, 1'b0, 32'h100, 32'h0, 32'h12345678, 0, 1'b0);
    checkOutput("word_load", 64'(data_out), 64'h12345678);
    applyStimulus(2'b01, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80A5A5A5, 0, 1'b0);
    checkOutput("sbyte_load", 64'(data_out), 64'hFFFFFF80);
    applyStimulus(2'b01, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80A5A5A5, 0, 1'b0);
    checkOutput("ubyte_load", 64'(data_out), 64'h00000080);
    applyStimulus(2'b10, 2'b01, 1'b0, 32'h202, 32'h0000BEEF, 32'h0, 0, 1'b0);
    checkOutput("store_keeps_data", 64'(data_out), 64'h00000080);
    applyStimulus(2'b01, 2'b10, 1'b0, 32'h104, 32'h0, 32'h11111111, 4, 1'b0);
    applyStimulus(2'b01, 2'b10, 1'b0, 32'h108, 32'h0, 32'hCAFEF00D, 2, 1'b0);
    applyStimulus(2'b01, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 0, 1'b0);
    applyStimulus(2'b01, 2'b01, 1'b1, 32'h10C, 32'h0, 32'h0, 0, 1'b1);

    $display("[TB] flush with ack");
    mau_op = 2'b01; mau_size = 2'b10; mau_sign = 1'b0; mau_addr = 32'h300;
    step();
    mau_op = 2'b00;
    checkOutput("fa_cyc_on", 64'(cyc_o), 64'(1));
    ack_i = 1'b1; dat_i = 32'hDEADBEEF; mau_flush = 1'b1;
    step();
    ack_i = 1'b0; mau_flush = 1'b0;
    checkOutput("fa_busy", 64'(busy), 64'(0));
    checkOutput("fa_cyc", 64'(cyc_o), 64'(0));
    checkOutput("fa_done", 64'(done), 64'(0));
    checkOutput("fa_data", 64'(data_out), 64'(exp_data));
    step();
    checkOutput("fa_nodone", 64'(done), 64'(0));

    $display("[TB] flush during retry gap");
    mau_op = 2'b01; mau_addr = 32'h400;
    step();
    mau_op = 2'b00;
    try_i = 1'b1;
    step();
    try_i = 1'b0;
    checkOutput("fw_wait_busy", 64'(busy), 64'(1));
    mau_flush = 1'b1;
    step();
    mau_flush = 1'b0;
    checkOutput("fw_busy", 64'(busy), 64'(0));
    step();
    checkOutput("fw_nodone", 64'(done), 64'(0));
    applyStimulus(2'b01, 2'b10, 1'b0, 32'h404, 32'h0, 32'h0BADCAFE, 3, 1'b0);

    $display("[TB] dropped requests");
    mau_op = 2'b01; mau_addr = 32'h500; mau_flush = 1'b1;
    step();
    mau_flush = 1'b0; mau_op = 2'b00;
    checkOutput("drop_flush_cyc", 64'(cyc_o), 64'(0));
    mau_op = 2'b10; mau_dis = 1'b1;
    step();
    mau_op = 2'b00; mau_dis = 1'b0;
    checkOutput("drop_dis_cyc", 64'(cyc_o), 64'(0));
    step();
    checkOutput("drop_done", 64'(done), 64'(0));

    $display("[TB] unterminated bus cycle");
    mau_op = 2'b01; mau_size = 2'b10; mau_addr = 32'h600;
    step();
    mau_op = 2'b00;
`ifdef I2D_MAU_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT_CYC; i++) begin
      checkOutput("tmo_cyc", 64'(cyc_o), 64'(1));
      step();
    end
    checkOutput("tmo_cyc_drop", 64'(cyc_o), 64'(0));
    checkOutput("tmo_done", 64'(done), 64'(1));
    checkOutput("tmo_err", 64'(mau_err), 64'(1));
    step();
`else
    for (int i = 0; i < 3 * TIMEOUT_CYC; i++) begin
      checkOutput("hang_cyc", 64'(cyc_o), 64'(1));
      step();
    end
    mau_flush = 1'b1;
    step();
    mau_flush = 1'b0;
    checkOutput("hang_flush_busy", 64'(busy), 64'(0));
    step();
`endif
    checkOutput("unterm_idle_done", 64'(done), 64'(0));

    $display("[TB] randomized accesses");
    for (int k = 0; k < 60; k++) begin
      r_op   = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'($urandom_range(1, 2));
      r_size = 2'($urandom_range(0, 3));
      r_addr = $urandom;
      if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
      applyStimulus(r_op, r_size, 1'($urandom), r_addr, $urandom, $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 5) == 0);
    end

    $display("[TB] asynchronous reset mid-access");
    mau_op = 2'b10; mau_size = 2'b10; mau_addr = 32'h700; datain = 32'h55AA55AA;
    step();
    mau_op = 2'b00;
    #2;
    rst = 1'b0;
    #1;
    exp_data = 32'h0;
    checkOutput("arst_cyc", 64'(cyc_o), 64'(0));
    checkOutput("arst_busy", 64'(busy), 64'(0));
    checkOutput("arst_sel", 64'(sel_o), 64'(0));
    checkOutput("arst_dat", 64'(dat_o), 64'(0));
    checkOutput("arst_data", 64'(data_out), 64'(exp_data));
    step();
    rst = 1'b1;
    step();
    applyStimulus(2'b01, 2'b01, 1'b1, 32'h702, 32'h0, 32'h8001FFFF, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2d_mau_wb.md
Name: i2d_mau_wb

Overview:
Parametrised memory access unit for the i2d core: next-generation MAU. Accepts one load/store request from the execute stage and runs a Wishbone classic single-beat cycle. Adds configurable data width, byte/half/word/dword sizing with lane steering and sign extension, bounded retry handling, misalignment trapping and flush-abort. Sits between the core pipeline and the data-side Wishbone bus.

Parameters:
AW, 32, address width
DW, 32, data width; 32 or 64 only
RETRY_MAX, 3, number of reissues allowed after try_i before an error is reported
RETRY_GAP, 2, idle cycles (cyc_o low) between a retry and the reissue; minimum 1
TIMEOUT_CYC, 255, bus watchdog limit in cycles; used only with I2D_MAU_TIMEOUT_EN

Ports:
clk  in  1  core clock; all state changes on the rising edge
rst  in  1  asynchronous, active-low reset
mau_dis  in  1  when high, new requests are not accepted
mau_flush  in  1  abort the current access and discard its result
mau_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
mau_size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when DW=64)
mau_sign  in  1  sign-extend load data
mau_addr  in  AW  byte address
datain  in  DW  store data, right-justified
data_out  out  DW  load result, right-justified and extended
busy  out  1  access in progress
done  out  1  one-cycle completion pulse
mau_err  out  1  qualifies done: bus error, retry exhaustion, misalignment or timeout
adr_o  out  AW  bus address, aligned to DW/8 bytes
dat_i  in  DW  bus read data
dat_o  out  DW  bus write data, replicated to the addressed lanes
ack_i  in  1  normal termination
err_i  in  1  error termination
try_i  in  1  retry termination
cyc_o  out  1  bus cycle
stb_o  out  1  strobe; equal to cyc_o
sel_o  out  DW/8  byte-lane selects
we_o  out  1  write enable

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0, including data_out and sel_o. Retry counter is 0.
- Accept: in IDLE with mau_op in {01,10} and mau_dis=0 and mau_flush=0. Requests are never accepted while busy; the request inputs are ignored.
- Misalignment check at accept: addr not a multiple of the size, or size 11 with DW=32. Result: no bus cycle, and done=1 with mau_err=1 on the next cycle.
- Otherwise the request goes to state BUS on the next edge with these registered outputs: cyc_o=stb_o=1, busy=1, adr_o={addr[AW-1:log2(DW/8)],0}, sel_o = size mask shifted by the low address bits, we_o, and dat_o = datain replicated per lane.
- BUS state, terminations sampled each edge with priority err_i > try_i > ack_i:
  - ack_i: cyc/stb drop on the next edge, then DONE.
  - err_i: DONE with mau_err.
  - try_i: if the retry count < RETRY_MAX, increment it and enter WAIT. Otherwise DONE with mau_err.
- WAIT: cyc_o=0 for RETRY_GAP cycles, then reissue the same cycle in BUS.
- Load data on ack: lanes shifted down by the low address bits, truncated to the size, then zero- or sign-extended per mau_sign. Registered into data_out in the same edge that leaves BUS.
- DONE lasts one cycle: done=1, busy=0, retry counter cleared, then IDLE.
- Minimum latency with zero-wait ack: accept edge at t, cyc_o high t+1, ack at t+1, done at t+2.
- data_out holds its value until the next load completes. Stores leave data_out unchanged.
- mau_flush in any non-IDLE state: IDLE on the next edge, cyc/stb/busy low, no done pulse, data discarded. Flush wins over a simultaneous ack, err or try.
- Flush has no effect in IDLE. A request arriving with flush set is dropped.

Optional Feature:
Macro I2D_MAU_TIMEOUT_EN.
- Defined: a cycle counter runs in BUS and resets on each entry to BUS. When it reaches TIMEOUT_CYC without a termination, cyc is dropped and the access ends with done+mau_err.
- Undefined: no counter is synthesised and BUS waits indefinitely.

Test Plan:
- DW=32 word load, addr 0x100, ack one cycle after cyc -> adr_o=0x100, sel_o=1111, done at t+2, data_out=dat_i.
- Signed byte load, addr 0x103, dat_i=0x80xxxxxx -> sel_o=1000, data_out=0xFFFFFF80. Same access unsigned -> 0x00000080.
- Half store 0xBEEF to addr 0x202 -> we_o=1, sel_o=1100, dat_o=0xBEEFBEEF, done with mau_err=0.
- try_i on 4 consecutive attempts with RETRY_MAX=3 -> 4 bus cycles separated by 2 idle cycles, then done+mau_err. try_i twice then ack -> 3 cycles, clean done.
- Word load at addr 0x101 -> no cyc_o, done+mau_err next cycle. Flush raised together with ack -> no done, data_out unchanged, busy low next cycle.
- With I2D_MAU_TIMEOUT_EN and TIMEOUT_CYC=8, bus never acks -> cyc_o drops after 8 cycles with done+mau_err.
